// File: rtl/coin_payout_if.sv
// coin_payout_if
//   Bundles the change-request handshake, the hopper pulse/ack pair, the
//   restock inputs and the result/status fields of the coin payout block.
//   master : the vending controller / hopper side (drives requests, acks, restock)
//   slave  : the coin_payout block itself
//   Parameters AMT_W / CNT_W must match the coin_payout instance.
interface coin_payout_if #(
  parameter int AMT_W = 8,
  parameter int CNT_W = 6
);
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             coin_ten;
  logic             coin_five;
  logic             coin_ack;
  logic             restock_valid;
  logic [CNT_W-1:0] restock_ten;
  logic [CNT_W-1:0] restock_five;
  logic [CNT_W-1:0] ten_left;
  logic [CNT_W-1:0] five_left;
  logic             done;
  logic [AMT_W-1:0] paid_amount;
  logic [AMT_W-1:0] shortfall;
  logic             err_odd;
  logic             err_jam;

  modport master (
    output req_valid, req_amount, coin_ack, restock_valid, restock_ten, restock_five,
    input  req_ready, coin_ten, coin_five, ten_left, five_left, done,
           paid_amount, shortfall, err_odd, err_jam
  );

  modport slave (
    input  req_valid, req_amount, coin_ack, restock_valid, restock_ten, restock_five,
    output req_ready, coin_ten, coin_five, ten_left, five_left, done,
           paid_amount, shortfall, err_odd, err_jam
  );
endinterface

// File: rtl/coin_payout.sv
// coin_payout
//   Change-dispensing back end. Accepts one change request, pays it out one
//   coin at a time (10-coins first, then 5-coins) through a pulse/ack hopper
//   handshake, keeps the hopper inventory, and reports paid / shortfall / errors.
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : coin_payout_if.slave -- request handshake, coin pulses and ack,
//            restock inputs, inventory levels and result fields
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a request; result fields hold the last outcome
// CHOOSE   | pick next coin (greedy ten, then five) or finish
// EJECT    | one-cycle coin pulse to the hopper
// WAIT_ACK | waiting for hopper ack, jam timer running
// DONE     | one-cycle done pulse, back to IDLE
module coin_payout #(
  parameter int AMT_W       = 8,
  parameter int CNT_W       = 6,
  parameter int INIT_TEN    = 20,
  parameter int INIT_FIVE   = 20,
  parameter int ACK_TIMEOUT = 15
) (
  input logic          clk,
  input logic          reset,
  coin_payout_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHOOSE,
    S_EJECT,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  localparam int               TMR_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AMT_W-1:0] TEN     = AMT_W'(10);
  localparam logic [AMT_W-1:0] FIVE    = AMT_W'(5);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;

  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] paid_q;
  logic [AMT_W-1:0] shortfall_q;
  logic             err_odd_q;
  logic             err_jam_q;
  logic             sel_ten;
  logic [TMR_W-1:0] ack_timer;
  logic [CNT_W-1:0] ten_inv;
  logic [CNT_W-1:0] five_inv;

  logic             accept;
  logic             amount_odd;
  logic             can_ten;
  logic             can_five;
  logic             ack_hit;
  logic             timeout;
  logic [AMT_W-1:0] denom;
  logic [CNT_W-1:0] add_ten;
  logic [CNT_W-1:0] add_five;

  assign accept     = bus.req_valid && (state == S_IDLE);
  assign amount_odd = (bus.req_amount % FIVE) != '0;
  assign can_ten    = (remaining >= TEN)  && (ten_inv  != '0);
  assign can_five   = (remaining >= FIVE) && (five_inv != '0);
  assign ack_hit    = (state == S_WAIT_ACK) && bus.coin_ack;
  // The timer counts completed no-ack cycles; the cycle that would bring it
  // to ACK_TIMEOUT is the last one spent in WAIT_ACK.
  assign timeout    = (state == S_WAIT_ACK) && !bus.coin_ack &&
                      (ack_timer == TMR_W'(ACK_TIMEOUT - 1));
  assign denom      = sel_ten ? TEN : FIVE;
  assign add_ten    = bus.restock_valid ? bus.restock_ten  : '0;
  assign add_five   = bus.restock_valid ? bus.restock_five : '0;

  // Net inventory update: add restock, remove an acked coin, clamp to the
  // counter range.
  function automatic logic [CNT_W-1:0] inv_update(
    input logic [CNT_W-1:0] inv,
    input logic [CNT_W-1:0] add,
    input logic             dec
  );
    logic [CNT_W:0] sum;
    sum = {1'b0, inv} + {1'b0, add};
    if (dec && (sum != '0)) begin
      sum = sum - (CNT_W+1)'(1);
    end
    if (sum > {1'b0, CNT_MAX}) begin
      return CNT_MAX;
    end
    return sum[CNT_W-1:0];
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = amount_odd ? S_DONE : S_CHOOSE;
        end
      end
      S_CHOOSE: begin
        if (remaining == '0) begin
          state_nxt = S_DONE;
        end else if (can_ten || can_five) begin
          state_nxt = S_EJECT;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_EJECT: begin
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_hit) begin
          state_nxt = S_CHOOSE;
        end else if (timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // output logic
  always_comb begin
    bus.req_ready = 1'b0;
    bus.coin_ten  = 1'b0;
    bus.coin_five = 1'b0;
    bus.done      = 1'b0;
    case (state)
      S_IDLE:  bus.req_ready = 1'b1;
      S_EJECT: begin
        bus.coin_ten  = sel_ten;
        bus.coin_five = !sel_ten;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // request datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining   <= '0;
      paid_q      <= '0;
      shortfall_q <= '0;
      err_odd_q   <= 1'b0;
      err_jam_q   <= 1'b0;
      sel_ten     <= 1'b0;
      ack_timer   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            remaining   <= bus.req_amount;
            paid_q      <= '0;
            err_jam_q   <= 1'b0;
            err_odd_q   <= amount_odd;
            shortfall_q <= amount_odd ? bus.req_amount : '0;
          end
        end
        S_CHOOSE: begin
          if (remaining != '0) begin
            if (can_ten) begin
              sel_ten <= 1'b1;
            end else if (can_five) begin
              sel_ten <= 1'b0;
            end else begin
              shortfall_q <= remaining;
            end
          end
        end
        S_EJECT: begin
          ack_timer <= '0;
        end
        S_WAIT_ACK: begin
          if (bus.coin_ack) begin
            remaining <= remaining - denom;
            paid_q    <= paid_q + denom;
          end else if (timeout) begin
            err_jam_q   <= 1'b1;
            shortfall_q <= remaining;
          end else begin
            ack_timer <= ack_timer + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // hopper inventory; restock is honoured in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      ten_inv  <= CNT_W'(INIT_TEN);
      five_inv <= CNT_W'(INIT_FIVE);
    end else begin
      ten_inv  <= inv_update(ten_inv,  add_ten,  ack_hit &&  sel_ten);
      five_inv <= inv_update(five_inv, add_five, ack_hit && !sel_ten);
    end
  end

  assign bus.ten_left    = ten_inv;
  assign bus.five_left   = five_inv;
  assign bus.paid_amount = paid_q;
  assign bus.shortfall   = shortfall_q;
  assign bus.err_odd     = err_odd_q;
  assign bus.err_jam     = err_jam_q;

endmodule

// File: tb/tb_coin_payout.sv
module tb_coin_payout;
  localparam int AMT_W       = 8;
  localparam int CNT_W       = 6;
  localparam int ACK_TIMEOUT = 15;

  logic clk;
  logic reset;

  coin_payout_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) ba ();
  coin_payout_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bb ();

  coin_payout #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_TEN(20), .INIT_FIVE(20), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ba)
  );

  coin_payout #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_TEN(1), .INIT_FIVE(2), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // pulse log: 1 = ten, 2 = five, most recent pulse is the last digit
  int seq_a = 0;
  int seq_b = 0;
  int n_pulse_a = 0;
  int done_cnt_a = 0;
  int ack_dly_a = 0;
  int pend_a = 0;
  logic ack_force_a = 1'b0;
  int pend_b = 0;

  // hopper model for dut_a: ack ack_dly_a cycles after each pulse (0 = never)
  always @(negedge clk) begin
    ba.coin_ack = ack_force_a;
    if (pend_a > 0) begin
      pend_a--;
      if (pend_a == 0 && ack_dly_a != 0) ba.coin_ack = 1'b1;
    end
    if (ba.coin_ten || ba.coin_five) begin
      seq_a = seq_a * 10 + (ba.coin_ten ? 1 : 2);
      n_pulse_a++;
      if (ack_dly_a > 0) pend_a = ack_dly_a;
    end
    if (ba.done) done_cnt_a++;
  end

  // hopper model for dut_b: always acks 2 cycles after a pulse
  always @(negedge clk) begin
    bb.coin_ack = 1'b0;
    if (pend_b > 0) begin
      pend_b--;
      if (pend_b == 0) bb.coin_ack = 1'b1;
    end
    if (bb.coin_ten || bb.coin_five) begin
      seq_b = seq_b * 10 + (bb.coin_ten ? 1 : 2);
      pend_b = 2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done_a(input int max, output int cyc);
    cyc = 0;
    while (!ba.done && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done_b(input int max, output int cyc);
    cyc = 0;
    while (!bb.done && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;
  int n0;
  int d0;

  initial begin
    reset = 1'b1;
    ba.req_valid = 1'b0; ba.req_amount = '0;
    ba.restock_valid = 1'b0; ba.restock_ten = '0; ba.restock_five = '0;
    bb.req_valid = 1'b0; bb.req_amount = '0;
    bb.restock_valid = 1'b0; bb.restock_ten = '0; bb.restock_five = '0;
    repeat (3) @(negedge clk);

    check("rst_req_ready", ba.req_ready, 1);
    check("rst_coin_ten", ba.coin_ten, 0);
    check("rst_coin_five", ba.coin_five, 0);
    check("rst_done", ba.done, 0);
    check("rst_paid", ba.paid_amount, 0);
    check("rst_shortfall", ba.shortfall, 0);
    check("rst_err_odd", ba.err_odd, 0);
    check("rst_err_jam", ba.err_jam, 0);
    check("rst_ten_left", ba.ten_left, 20);
    check("rst_five_left", ba.five_left, 20);
    check("rst_b_ten_left", bb.ten_left, 1);
    check("rst_b_five_left", bb.five_left, 2);
    reset = 1'b0;
    @(negedge clk);

    // 1: req 35, ack 2 cycles after each pulse
    seq_a = 0; ack_dly_a = 2;
    ba.req_valid = 1'b1; ba.req_amount = 8'd35;
    @(negedge clk);
    ba.req_valid = 1'b0;
    check("t1_no_pulse_t1", ba.coin_ten, 0);
    @(negedge clk);
    check("t1_first_pulse_t2", ba.coin_ten, 1);
    wait_done_a(80, cyc);
    check("t1_done", ba.done, 1);
    check("t1_seq", seq_a, 1112);
    check("t1_paid", ba.paid_amount, 35);
    check("t1_shortfall", ba.shortfall, 0);
    check("t1_ten_left", ba.ten_left, 17);
    check("t1_five_left", ba.five_left, 19);
    check("t1_err_odd", ba.err_odd, 0);
    check("t1_err_jam", ba.err_jam, 0);
    @(negedge clk);
    check("t1_done_one_cycle", ba.done, 0);
    check("t1_paid_hold", ba.paid_amount, 35);

    // 2: small inventory 1/2, req 30
    seq_b = 0;
    bb.req_valid = 1'b1; bb.req_amount = 8'd30;
    @(negedge clk);
    bb.req_valid = 1'b0;
    wait_done_b(80, cyc);
    check("t2_done", bb.done, 1);
    check("t2_seq", seq_b, 122);
    check("t2_paid", bb.paid_amount, 20);
    check("t2_shortfall", bb.shortfall, 10);
    check("t2_ten_left", bb.ten_left, 0);
    check("t2_five_left", bb.five_left, 0);
    @(negedge clk);

    // 3: odd request 23 goes straight to DONE
    n0 = n_pulse_a;
    ba.req_valid = 1'b1; ba.req_amount = 8'd23;
    @(negedge clk);
    ba.req_valid = 1'b0;
    check("t3_done", ba.done, 1);
    check("t3_err_odd", ba.err_odd, 1);
    check("t3_paid", ba.paid_amount, 0);
    check("t3_shortfall", ba.shortfall, 23);
    repeat (3) @(negedge clk);
    check("t3_err_odd_hold", ba.err_odd, 1);
    check("t3_no_pulses", n_pulse_a, n0);

    // zero request: CHOOSE then DONE, nothing paid
    ba.req_valid = 1'b1; ba.req_amount = 8'd0;
    @(negedge clk);
    ba.req_valid = 1'b0;
    check("z_done_early", ba.done, 0);
    @(negedge clk);
    check("z_done", ba.done, 1);
    check("z_paid", ba.paid_amount, 0);
    check("z_shortfall", ba.shortfall, 0);
    check("z_err_odd_clr", ba.err_odd, 0);
    check("z_no_pulses", n_pulse_a, n0);

    // 4: hopper never acks -> jam
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ack_dly_a = 0; seq_a = 0; n0 = n_pulse_a;
    ba.req_valid = 1'b1; ba.req_amount = 8'd35;
    @(negedge clk);
    ba.req_valid = 1'b0;
    @(negedge clk);
    check("t4_pulse", ba.coin_ten, 1);
    wait_done_a(40, cyc);
    // pulse cycle, then ACK_TIMEOUT cycles in WAIT_ACK, then DONE
    check("t4_done", ba.done, 1);
    check("t4_jam_latency", cyc, ACK_TIMEOUT + 1);
    check("t4_err_jam", ba.err_jam, 1);
    check("t4_err_odd", ba.err_odd, 0);
    check("t4_paid", ba.paid_amount, 0);
    check("t4_shortfall", ba.shortfall, 35);
    check("t4_ten_left", ba.ten_left, 20);
    check("t4_one_pulse", n_pulse_a, n0 + 1);
    @(negedge clk);

    // 5: restock saturation, restock + ack net, stray ack in IDLE
    ba.restock_valid = 1'b1; ba.restock_ten = 6'd63; ba.restock_five = 6'd0;
    @(negedge clk);
    ba.restock_valid = 1'b0;
    check("t5_ten_sat", ba.ten_left, 63);
    check("t5_five_keep", ba.five_left, 20);
    ack_dly_a = 2; seq_a = 0;
    ba.req_valid = 1'b1; ba.req_amount = 8'd5;
    @(negedge clk);
    ba.req_valid = 1'b0;
    @(negedge clk);
    check("t5_five_pulse", ba.coin_five, 1);
    @(negedge clk);
    @(negedge clk);
    ba.restock_valid = 1'b1; ba.restock_ten = 6'd0; ba.restock_five = 6'd1;
    @(negedge clk);
    ba.restock_valid = 1'b0; ba.restock_five = 6'd0;
    check("t5_five_net", ba.five_left, 20);
    check("t5_ten_net", ba.ten_left, 63);
    wait_done_a(20, cyc);
    check("t5_done", ba.done, 1);
    check("t5_paid", ba.paid_amount, 5);
    @(negedge clk);
    n0 = n_pulse_a;
    ack_force_a = 1'b1;
    ba.restock_valid = 1'b1; ba.restock_ten = 6'd0; ba.restock_five = 6'd0;
    @(negedge clk);
    ack_force_a = 1'b0; ba.restock_valid = 1'b0;
    @(negedge clk);
    check("t5_stray_ten", ba.ten_left, 63);
    check("t5_stray_five", ba.five_left, 20);
    check("t5_stray_ready", ba.req_ready, 1);
    check("t5_stray_no_pulse", n_pulse_a, n0);

    // 6: reset during WAIT_ACK of the second coin
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ack_dly_a = 2; n0 = n_pulse_a;
    ba.req_valid = 1'b1; ba.req_amount = 8'd35;
    @(negedge clk);
    ba.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_ten_before", ba.ten_left, 19);
    check("t6_in_wait", ba.req_ready, 0);
    d0 = done_cnt_a;
    reset = 1'b1; ack_dly_a = 0;
    @(negedge clk);
    reset = 1'b0;
    check("t6_ready", ba.req_ready, 1);
    check("t6_no_done", ba.done, 0);
    check("t6_ten_reload", ba.ten_left, 20);
    check("t6_five_reload", ba.five_left, 20);
    check("t6_paid_clr", ba.paid_amount, 0);
    repeat (20) @(negedge clk);
    check("t6_done_count", done_cnt_a, d0);
    check("t6_pulse_count", n_pulse_a, n0 + 2);
    check("t6_idle", ba.req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
